// File: rtl/wb_arb.sv
// wb_arb -- register-file writeback arbiter for two result sources (ALU, LSU).
//
// Each source feeds a one-entry holding buffer. Load data is byte/half/word
// formatted and extended before it is captured. Every cycle at most one full
// buffer is granted onto the registered rf_* write port. The LSU wins by
// default. If the LSU won last cycle and the ALU buffer is full, the ALU wins,
// so neither source waits more than one cycle. Writes to x0 are consumed
// without raising rf_wen.
//
// Optional feature: define WB_ARB_RETIRE_CNT_EN to add the 32-bit retire_cnt
// output. It counts the cycles in which rf_wen is high and wraps to zero.

module wb_arb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,

    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic [1:0]            lsu_size,
    input  logic                  lsu_unsigned,
    input  logic [1:0]            lsu_offset,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef WB_ARB_RETIRE_CNT_EN
    ,
    output logic [31:0]           retire_cnt
`endif
);

    // Arbitration history. PRI_ALU means the LSU was granted last cycle, so a
    // full ALU buffer takes priority this cycle.
    typedef enum logic {
        PRI_LSU = 1'b0,
        PRI_ALU = 1'b1
    } pri_e;

    pri_e pri_q, pri_d;

    logic                  alu_full;
    logic [ADDR_WIDTH-1:0] alu_buf_rd;
    logic [DATA_WIDTH-1:0] alu_buf_data;

    logic                  lsu_full;
    logic [ADDR_WIDTH-1:0] lsu_buf_rd;
    logic [DATA_WIDTH-1:0] lsu_buf_data;

    logic                  grant_alu;
    logic                  grant_lsu;
    logic                  alu_accept;
    logic                  lsu_accept;

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic                  ext_bit;
    logic [DATA_WIDTH-1:0] lsu_fmt;

    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    // Load formatting: pick the byte or half, then zero- or sign-extend it.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        ext_bit  = 1'b0;
        lsu_fmt  = lsu_data;

        case (lsu_offset)
            2'd0:    byte_sel = lsu_data[7:0];
            2'd1:    byte_sel = lsu_data[15:8];
            2'd2:    byte_sel = lsu_data[23:16];
            default: byte_sel = lsu_data[31:24];
        endcase

        // Half loads ignore offset bit 0.
        half_sel = lsu_offset[1] ? lsu_data[31:16] : lsu_data[15:0];

        case (lsu_size)
            2'd0: begin
                ext_bit = !lsu_unsigned && byte_sel[7];
                lsu_fmt = {{(DATA_WIDTH-8){ext_bit}}, byte_sel};
            end
            2'd1: begin
                ext_bit = !lsu_unsigned && half_sel[15];
                lsu_fmt = {{(DATA_WIDTH-16){ext_bit}}, half_sel};
            end
            default: lsu_fmt = lsu_data;
        endcase
    end

    // Arbitration: choose at most one full buffer, and compute the next history state.
    always_comb begin
        grant_lsu = 1'b0;
        grant_alu = 1'b0;
        pri_d     = PRI_LSU;

        if (lsu_full && !(pri_q == PRI_ALU && alu_full)) begin
            grant_lsu = 1'b1;
        end else if (alu_full) begin
            grant_alu = 1'b1;
        end

        if (grant_lsu) begin
            pri_d = PRI_ALU;
        end
    end

    // A buffer can take a new entry when it is empty or is being drained this cycle.
    assign alu_ready  = !alu_full || grant_alu;
    assign lsu_ready  = !lsu_full || grant_lsu;
    assign alu_accept = alu_valid && alu_ready;
    assign lsu_accept = lsu_valid && lsu_ready;

    // Register the arbitration history. Reset restores LSU priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
            pri_q <= PRI_LSU;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Buffer full flags. A new entry takes precedence over a drain, so an
    // accept and a grant in the same cycle leave the buffer full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_full <= 1'b0;
            lsu_full <= 1'b0;
        end else begin
            if (alu_accept) begin
                alu_full <= 1'b1;
            end else if (grant_alu) begin
                alu_full <= 1'b0;
            end

            if (lsu_accept) begin
                lsu_full <= 1'b1;
            end else if (grant_lsu) begin
                lsu_full <= 1'b0;
            end
        end
    end

    // Buffer payloads. They are captured on accept and are only meaningful while full is set.
    always_ff @(posedge clk) begin
        // NOTE: payload registers have no reset; the full flags already gate them, so clearing them would add reset fan-out and change nothing.
        if (alu_accept) begin
            alu_buf_rd   <= alu_rd;
            alu_buf_data <= alu_data;
        end
        if (lsu_accept) begin
            lsu_buf_rd   <= lsu_rd;
            lsu_buf_data <= lsu_fmt;
        end
    end

    // Steer the granted buffer onto the write port.
    always_comb begin
        sel_rd   = alu_buf_rd;
        sel_data = alu_buf_data;
        if (grant_lsu) begin
            sel_rd   = lsu_buf_rd;
            sel_data = lsu_buf_data;
        end
    end

    // Registered write port. rd=0 entries are consumed without a write.
    // Address and data hold their values when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_lsu || grant_alu) begin
            rf_wen   <= (sel_rd != '0);
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

`ifdef WB_ARB_RETIRE_CNT_EN
    // Retire counter: add one for every cycle rf_wen is high, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= 32'd0;
        end else if (rf_wen) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`else
    // No retire counter in this build.
`endif

endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb -- self-checking bench for wb_arb.
// A table of single transactions covers ALU writes, load formatting and x0
// writes. Hand-written sequences then cover the alternating arbitration under
// load and a reset asserted mid-cycle. Retire-counter checks compile only when
// WB_ARB_RETIRE_CNT_EN is defined.

module tb_wb_arb;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic [1:0]    lsu_size;
    logic          lsu_unsigned;
    logic [1:0]    lsu_offset;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef WB_ARB_RETIRE_CNT_EN
    logic [31:0]   retire_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .lsu_offset   (lsu_offset),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
`ifdef WB_ARB_RETIRE_CNT_EN
        ,
        .retire_cnt   (retire_cnt)
`endif
    );

    typedef struct packed {
        logic          is_lsu;
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        logic [1:0]    size;
        logic          uns;
        logic [1:0]    off;
        logic          exp_wen;
        logic [DW-1:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one transaction, then check the write two edges later and the idle cycle after it.
    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        if (v.is_lsu) begin
            lsu_valid    = 1'b1;
            lsu_rd       = v.rd;
            lsu_data     = v.data;
            lsu_size     = v.size;
            lsu_unsigned = v.uns;
            lsu_offset   = v.off;
        end else begin
            alu_valid = 1'b1;
            alu_rd    = v.rd;
            alu_data  = v.data;
        end
        @(negedge clk);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        check($sformatf("vec%0d wen before write", idx), {31'd0, rf_wen}, 32'd0);
        @(negedge clk);
        check($sformatf("vec%0d wen", idx), {31'd0, rf_wen}, {31'd0, v.exp_wen});
        if (v.exp_wen) begin
            check($sformatf("vec%0d waddr", idx), {27'd0, rf_waddr}, {27'd0, v.rd});
            check($sformatf("vec%0d wdata", idx), rf_wdata, v.exp_data);
        end
        @(negedge clk);
        check($sformatf("vec%0d wen after", idx), {31'd0, rf_wen}, 32'd0);
    endtask

    // Watchdog: the bench must always end on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   ai, li, wr;
        int   alu_low, lsu_low, alu_low_max, lsu_low_max;
        int   wr_cnt;
        logic [AW-1:0] exp_rd;
        logic [DW-1:0] exp_wd;

        vecs[0] = '{1'b0, 5'd5,  32'h0000_1234, 2'd0, 1'b0, 2'd0, 1'b1, 32'h0000_1234};
        vecs[1] = '{1'b0, 5'd0,  32'h0000_DEAD, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0000_0000};
        vecs[2] = '{1'b1, 5'd3,  32'h80FF_0011, 2'd0, 1'b0, 2'd3, 1'b1, 32'hFFFF_FF80};
        vecs[3] = '{1'b1, 5'd4,  32'h80FF_0011, 2'd0, 1'b1, 2'd3, 1'b1, 32'h0000_0080};
        vecs[4] = '{1'b1, 5'd6,  32'h80FF_0011, 2'd1, 1'b0, 2'd2, 1'b1, 32'hFFFF_80FF};
        vecs[5] = '{1'b1, 5'd7,  32'h80FF_0011, 2'd1, 1'b1, 2'd3, 1'b1, 32'h0000_80FF};
        vecs[6] = '{1'b1, 5'd8,  32'h80FF_0011, 2'd0, 1'b0, 2'd2, 1'b1, 32'hFFFF_FFFF};
        vecs[7] = '{1'b1, 5'd9,  32'h80FF_0011, 2'd0, 1'b0, 2'd0, 1'b1, 32'h0000_0011};
        vecs[8] = '{1'b1, 5'd10, 32'h80FF_0011, 2'd1, 1'b0, 2'd1, 1'b1, 32'h0000_0011};
        vecs[9] = '{1'b1, 5'd31, 32'h80FF_0011, 2'd3, 1'b0, 2'd1, 1'b1, 32'h80FF_0011};

        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        lsu_size = 2'd0; lsu_unsigned = 1'b0; lsu_offset = 2'd0;

        // Reset state.
        #12;
        check("reset rf_wen", {31'd0, rf_wen}, 32'd0);
        check("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
        check("reset rf_wdata", rf_wdata, 32'd0);
        check("reset alu_ready", {31'd0, alu_ready}, 32'd1);
        check("reset lsu_ready", {31'd0, lsu_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset alu_ready", {31'd0, alu_ready}, 32'd1);
        check("post-reset lsu_ready", {31'd0, lsu_ready}, 32'd1);
`ifdef WB_ARB_RETIRE_CNT_EN
        check("reset retire_cnt", retire_cnt, 32'd0);
`endif

        // Single-transaction table.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end
`ifdef WB_ARB_RETIRE_CNT_EN
        // 9 table entries wrote a nonzero rd.
        check("retire_cnt after table", retire_cnt, 32'd9);
`endif

        // Both sources valid for 6 edges: writes must alternate L0,A0,L1,A1,L2,A2,L3.
        ai = 0; li = 0; wr = 0;
        alu_low = 0; lsu_low = 0; alu_low_max = 0; lsu_low_max = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (rf_wen) begin
                if (wr % 2 == 0) begin
                    exp_rd = AW'(10 + wr / 2);
                    exp_wd = 32'h1000_0000 + 32'(wr / 2);
                end else begin
                    exp_rd = AW'(20 + wr / 2);
                    exp_wd = 32'h2000_0000 + 32'(wr / 2);
                end
                check($sformatf("alt write%0d waddr", wr), {27'd0, rf_waddr}, {27'd0, exp_rd});
                check($sformatf("alt write%0d wdata", wr), rf_wdata, exp_wd);
                wr++;
            end
            if (cyc < 6) begin
                alu_valid = 1'b1;
                alu_rd    = AW'(20 + ai);
                alu_data  = 32'h2000_0000 + 32'(ai);
                lsu_valid = 1'b1;
                lsu_rd    = AW'(10 + li);
                lsu_data  = 32'h1000_0000 + 32'(li);
                lsu_size  = 2'd2;
                lsu_offset = 2'd0;
                alu_low = alu_ready ? 0 : alu_low + 1;
                lsu_low = lsu_ready ? 0 : lsu_low + 1;
                if (alu_low > alu_low_max) alu_low_max = alu_low;
                if (lsu_low > lsu_low_max) lsu_low_max = lsu_low;
                if (alu_ready) ai++;
                if (lsu_ready) li++;
            end else begin
                alu_valid = 1'b0;
                lsu_valid = 1'b0;
            end
        end
        check("alt write count", 32'(wr), 32'd7);
        check("alt alu_ready longest low run", 32'(alu_low_max), 32'd1);
        check("alt lsu_ready longest low run", 32'(lsu_low_max), 32'd1);

        // Reset mid-cycle with both buffers full and a write on the port.
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hAAAA_0007;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'hBBBB_0008; lsu_size = 2'd2;
        @(negedge clk);
        lsu_rd = 5'd9; lsu_data = 32'hBBBB_0009;
        @(negedge clk);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        check("pre-reset write wen", {31'd0, rf_wen}, 32'd1);
        check("pre-reset write waddr", {27'd0, rf_waddr}, 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset rf_wen", {31'd0, rf_wen}, 32'd0);
        check("mid reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
        check("mid reset rf_wdata", rf_wdata, 32'd0);
        check("mid reset alu_ready", {31'd0, alu_ready}, 32'd1);
        check("mid reset lsu_ready", {31'd0, lsu_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        wr_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rf_wen) wr_cnt++;
        end
        check("writes after reset release", 32'(wr_cnt), 32'd0);

`ifdef WB_ARB_RETIRE_CNT_EN
        check("retire_cnt after reset", retire_cnt, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            vec_t v;
            v = '{1'b0, AW'(i), 32'h0000_0100 + 32'(i), 2'd0, 1'b0, 2'd0, 1'b1, 32'h0000_0100 + 32'(i)};
            run_vec(v, 100 + i);
        end
        check("retire_cnt three writes", retire_cnt, 32'd3);
        run_vec(vecs[1], 104);
        check("retire_cnt x0 write", retire_cnt, 32'd3);

        // Preload the counter to all ones while a write is on the port, then check the wrap.
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_0404;
        @(negedge clk);
        alu_valid = 1'b0;
        @(negedge clk);
        check("wrap write wen", {31'd0, rf_wen}, 32'd1);
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        @(negedge clk);
        check("retire_cnt wrap", retire_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register index width.
REQ-002 Parameter DATA_WIDTH, default 32, register data width (byte/half load formatting fixed for 32).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 alu_valid  input  1  ALU result offered.
REQ-006 alu_ready  output  1  ALU result accepted when alu_valid && alu_ready at rising edge.
REQ-007 alu_rd  input  ADDR_WIDTH  ALU destination register.
REQ-008 alu_data  input  DATA_WIDTH  ALU result.
REQ-009 lsu_valid  input  1  load result offered.
REQ-010 lsu_ready  output  1  load result accepted when lsu_valid && lsu_ready at rising edge.
REQ-011 lsu_rd  input  ADDR_WIDTH  load destination register.
REQ-012 lsu_data  input  DATA_WIDTH  raw aligned memory word.
REQ-013 lsu_size  input  2  0 byte, 1 half, 2/3 word.
REQ-014 lsu_unsigned  input  1  1 zero-extend, 0 sign-extend.
REQ-015 lsu_offset  input  2  byte offset within word.
REQ-016 rf_wen  output  1  register-file write enable, registered.
REQ-017 rf_waddr  output  ADDR_WIDTH  register-file write index, registered.
REQ-018 rf_wdata  output  DATA_WIDTH  register-file write data, registered.

Function
REQ-019 Each source SHALL own a one-entry holding buffer (full flag, rd, data); load data SHALL be formatted before capture.
REQ-020 Byte load SHALL select lsu_data[8*lsu_offset +: 8]; half load SHALL select half lsu_offset[1], ignoring lsu_offset[0]; word SHALL pass unchanged.
REQ-021 Extension SHALL be zero when lsu_unsigned=1, sign of selected MSB otherwise.
REQ-022 Each cycle at most one full buffer SHALL be granted; a granted buffer SHALL empty at the next edge while rf_wen/rf_waddr/rf_wdata load its contents.
REQ-023 Arbitration: LSU wins by default; if LSU was granted in the previous cycle and ALU buffer is full, ALU SHALL win (no source starves beyond one cycle).
REQ-024 src_ready SHALL equal !full || granted-this-cycle (combinational), giving one result per cycle per source at full throughput.
REQ-025 Latency: result accepted at edge N SHALL appear on rf_* during the cycle after edge N+1 if uncontended.
REQ-026 With no grant, rf_wen SHALL be 0 next cycle; rf_waddr/rf_wdata SHALL hold previous values.
REQ-027 A granted entry with rd=0 SHALL be consumed but rf_wen SHALL remain 0 (x0 never written).
REQ-028 Simultaneous accept and grant on the same buffer SHALL leave it full with the new entry.

Reset
REQ-029 rst_n low SHALL immediately clear both full flags, rf_wen=0, rf_waddr=0, rf_wdata=0, arbitration history to LSU-default.
REQ-030 Reset mid-operation SHALL discard pending entries; no write SHALL issue for them after release.
REQ-031 alu_ready and lsu_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-032 Macro WB_ARB_RETIRE_CNT_EN defined: output retire_cnt (32 bits) SHALL count cycles with rf_wen=1, reset to 0, wrapping 0xFFFFFFFF->0.
REQ-033 Macro undefined: port retire_cnt and counter SHALL not exist; all other behaviour identical.

Verification
REQ-034 ALU only: alu_rd=5, alu_data=0x1234 accepted edge N -> rf_wen=1, rf_waddr=5, rf_wdata=0x1234 after edge N+1, then rf_wen=0.
REQ-035 Load byte signed: lsu_data=0x80FF0011, offset=3, size=0 -> rf_wdata=0xFFFFFF80; unsigned -> 0x00000080; half offset=2 signed -> 0xFFFF80FF.
REQ-036 Both valid every cycle for 6 cycles -> writes alternate LSU, ALU, LSU, ...; neither ready stays low more than one cycle.
REQ-037 alu_rd=0, alu_data=0xDEAD -> entry consumed, rf_wen never 1, retire_cnt unchanged (macro on).
REQ-038 Both buffers full, rst_n asserted low mid-cycle -> rf_wen=0 immediately; after release no write for discarded entries.
REQ-039 Macro on: 3 non-x0 writes -> retire_cnt=3; preload 0xFFFFFFFF and one write -> 0.
